rw_burst_seq: RTL and testbench
===============================

RW_BURST_SEQ -- requirements
Module: rw_burst_seq

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
- REQ-002 The block SHALL have these parameters:
  - ADDR_W, default 8, address width.
  - CNT_W, default 8, width of burst length and delay count.
- REQ-003 The block SHALL have these ports:
  - clk  input  1  clock, all state updates on rising edge.
  - rst  input  1  synchronous active-high reset.
  - start  input  1  begin a burst (sampled in IDLE only).
  - stop  input  1  request early termination.
  - slowrun  input  1  insert delay after each write.
  - base_addr  input  ADDR_W  first transfer address.
  - burst_len  input  CNT_W  number of read/write transfers.
  - delay_cycles  input  CNT_W  delay length per transfer when slowrun.
  - Read  output  1  read strobe.
  - Write  output  1  write strobe.
  - addr  output  ADDR_W  current transfer address.
  - busy  output  1  burst in progress.
  - done  output  1  one-cycle burst-complete pulse.

Function
- REQ-004 The FSM SHALL have five states: IDLE, READ, WRITE, DELAY, DONE.
- REQ-005 Read, Write, busy and done SHALL be Moore decodes of the registered state:
  - Read=1 only in READ.
  - Write=1 only in WRITE.
  - busy=1 in READ, WRITE and DELAY.
  - done=1 only in DONE.
- REQ-006 In IDLE, when start=1 and burst_len!=0, the block SHALL go to READ next cycle.
  - On that edge it SHALL latch addr=base_addr, remaining=burst_len and dly_len=delay_cycles.
- REQ-007 In IDLE, start=1 with burst_len==0 SHALL be ignored; the block stays in IDLE.
- REQ-008 While busy=1, start SHALL be ignored, and changes to base_addr, burst_len and delay_cycles SHALL have no effect until the next accepted start.
- REQ-009 READ SHALL last exactly one cycle and always be followed by WRITE at the same addr.
- REQ-010 On leaving WRITE:
  - slowrun is sampled in the WRITE cycle.
  - If slowrun=1 and dly_len!=0, the next state SHALL be DELAY.
  - Otherwise the transfer ends: go to READ if remaining>1, else DONE.
- REQ-011 DELAY SHALL last exactly dly_len cycles, with Read=Write=0.
  - It then ends the transfer as in REQ-010.
  - slowrun=1 with dly_len==0 SHALL behave as slowrun=0.
- REQ-012 At each transfer end, addr SHALL increment by 1 modulo 2^ADDR_W (all-ones wraps to 0) and remaining SHALL decrement by 1.
- REQ-013 DONE SHALL last one cycle and then return to IDLE.
  - addr SHALL hold its last incremented value in DONE and IDLE.
- REQ-014 stop=1 SHALL take effect only at a transfer end.
  - The next state SHALL be DONE regardless of remaining.
  - A started READ/WRITE pair SHALL never be split.
- REQ-015 stop=1 in IDLE or DONE SHALL have no effect; stop has priority over start in IDLE (start ignored that cycle).
- REQ-016 Exactly one of Read or Write, or neither, SHALL be asserted in any cycle; both high is illegal.
- REQ-017 Any state encoding outside the five states SHALL return to IDLE next cycle with all strobes 0.

Reset
- REQ-018 When rst=1 at a rising edge, the block SHALL go to IDLE with:
  - Read=0, Write=0, busy=0, done=0.
  - addr=0, remaining=0, dly_len=0, internal delay counter=0.
- REQ-019 Reset SHALL override start, stop and any in-progress burst, including mid-READ, mid-WRITE and mid-DELAY.
  - No done pulse SHALL be produced for an aborted burst.

Verification
- REQ-020 The bench SHALL cover these scenarios:
  - Basic burst: base_addr=0x10, burst_len=3, slowrun=0, start in cycle 0 -> Read in cycles 1,3,5; Write in cycles 2,4,6 at addr 0x10,0x11,0x12; done in cycle 7; busy=1 in cycles 1-6.
  - Slowrun delay: burst_len=2, slowrun=1, delay_cycles=2 -> sequence R,W,D,D,R,W,D,D, then done; slowrun=1 with delay_cycles=0 -> timing identical to slowrun=0.
  - Address wrap: ADDR_W=8, base_addr=0xFE, burst_len=3 -> writes at 0xFE, 0xFF, 0x00; addr=0x01 in DONE.
  - Early stop: burst_len=5, stop pulsed during the 2nd READ -> 2nd WRITE completes, then done, with exactly 2 Write pulses total.
  - Zero/ignored start: burst_len=0 start -> stays IDLE, no strobes; start asserted while busy -> no restart, addr sequence unaffected.
  - Reset mid-burst: rst in a DELAY cycle -> next cycle IDLE with all outputs 0, no done pulse; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/rw_burst_seq.sv
// rtl/rw_burst_seq.sv - read-then-write burst sequencer with optional per-transfer delay
module rw_burst_seq #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              slowrun,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  delay_cycles,
  output logic              Read,
  output logic              Write,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DELAY = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           xfer_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] dly_len;
  logic [CNT_W-1:0] dcnt;
  logic             stop_pend;
  logic             end_stop;

  // A stop pulse seen anywhere in a transfer is held until that transfer ends.
  assign end_stop  = stop | stop_pend;
  assign xfer_next = (end_stop || remaining <= 1) ? DONE : READ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      dly_len   <= '0;
      dcnt      <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (!stop && start && burst_len != '0) begin
            state     <= READ;
            addr      <= base_addr;
            remaining <= burst_len;
            dly_len   <= delay_cycles;
          end
        end
        READ: begin
          stop_pend <= end_stop;
          state     <= WRITE;
        end
        WRITE: begin
          if (slowrun && dly_len != '0) begin
            state     <= DELAY;
            dcnt      <= dly_len - 1'b1;
            stop_pend <= end_stop;
          end else begin
            state     <= xfer_next;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            stop_pend <= 1'b0;
          end
        end
        DELAY: begin
          if (dcnt == '0) begin
            state     <= xfer_next;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            stop_pend <= 1'b0;
          end else begin
            dcnt      <= dcnt - 1'b1;
            stop_pend <= end_stop;
          end
        end
        DONE: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
        end
      endcase
    end
  end

  assign Read  = (state == READ);
  assign Write = (state == WRITE);
  assign busy  = (state == READ) || (state == WRITE) || (state == DELAY);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_rw_burst_seq.sv
// tb/tb_rw_burst_seq.sv - directed self-checking bench for rw_burst_seq
module tb_rw_burst_seq;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  // per-cycle output code {done, busy, Write, Read}
  localparam logic [3:0] CI = 4'h0;
  localparam logic [3:0] CR = 4'h5;
  localparam logic [3:0] CW = 4'h6;
  localparam logic [3:0] CD = 4'h4;
  localparam logic [3:0] CK = 4'h8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              slowrun;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  burst_len;
  logic [CNT_W-1:0]  delay_cycles;
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  rw_burst_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .slowrun(slowrun),
    .base_addr(base_addr), .burst_len(burst_len), .delay_cycles(delay_cycles),
    .Read(Read), .Write(Write), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; stop = 1'b0; slowrun = 1'b0;
    base_addr = 8'h33; burst_len = 8'd4; delay_cycles = 8'd0;
    tick; tick;
    checks++;
    if ({done, busy, Write, Read} !== CI) begin
      errors++; $display("FAIL reset_strobes got %h exp %h", {done, busy, Write, Read}, CI);
    end
    checks++;
    if (addr !== 8'h00) begin
      errors++; $display("FAIL reset_addr got %h exp 00", addr);
    end
    rst = 1'b0; start = 1'b0;
    tick;
    checks++;
    if ({done, busy, Write, Read} !== CI) begin
      errors++; $display("FAIL reset_idle got %h exp %h", {done, busy, Write, Read}, CI);
    end
  endtask

  task automatic test_basic;
    logic [4*8-1:0] es;
    logic [8*8-1:0] ea;
    es = {CR, CW, CR, CW, CR, CW, CK, CI};
    ea = {8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13};
    base_addr = 8'h10; burst_len = 8'd3; slowrun = 1'b0; delay_cycles = 8'd5; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(8-c) +: 4]) begin
        errors++; $display("FAIL basic_strobes cycle %0d got %h exp %h", c, {done, busy, Write, Read}, es[4*(8-c) +: 4]);
      end
      checks++;
      if (addr !== ea[8*(8-c) +: 8]) begin
        errors++; $display("FAIL basic_addr cycle %0d got %h exp %h", c, addr, ea[8*(8-c) +: 8]);
      end
    end
  endtask

  task automatic test_slowrun;
    logic [4*10-1:0] es;
    logic [8*10-1:0] ea;
    logic [4*6-1:0]  es0;
    logic [8*6-1:0]  ea0;
    es = {CR, CW, CD, CD, CR, CW, CD, CD, CK, CI};
    ea = {8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
    base_addr = 8'h40; burst_len = 8'd2; slowrun = 1'b1; delay_cycles = 8'd2; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(10-c) +: 4] || addr !== ea[8*(10-c) +: 8]) begin
        errors++; $display("FAIL slowrun cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es[4*(10-c) +: 4], ea[8*(10-c) +: 8]);
      end
    end
    es0 = {CR, CW, CR, CW, CK, CI};
    ea0 = {8'h20, 8'h20, 8'h21, 8'h21, 8'h22, 8'h22};
    base_addr = 8'h20; burst_len = 8'd2; slowrun = 1'b1; delay_cycles = 8'd0; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es0[4*(6-c) +: 4] || addr !== ea0[8*(6-c) +: 8]) begin
        errors++; $display("FAIL slowrun_zero cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es0[4*(6-c) +: 4], ea0[8*(6-c) +: 8]);
      end
    end
    slowrun = 1'b0;
  endtask

  task automatic test_wrap;
    logic [4*8-1:0] es;
    logic [8*8-1:0] ea;
    es = {CR, CW, CR, CW, CR, CW, CK, CI};
    ea = {8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
    base_addr = 8'hFE; burst_len = 8'd3; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(8-c) +: 4] || addr !== ea[8*(8-c) +: 8]) begin
        errors++; $display("FAIL wrap cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es[4*(8-c) +: 4], ea[8*(8-c) +: 8]);
      end
    end
  endtask

  task automatic test_early_stop;
    logic [4*6-1:0] es;
    logic [8*6-1:0] ea;
    int             writes;
    es = {CR, CW, CR, CW, CK, CI};
    ea = {8'h30, 8'h30, 8'h31, 8'h31, 8'h32, 8'h32};
    writes = 0;
    base_addr = 8'h30; burst_len = 8'd5; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      start = 1'b0;
      stop  = (c == 3);
      if (Write) writes++;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(6-c) +: 4] || addr !== ea[8*(6-c) +: 8]) begin
        errors++; $display("FAIL early_stop cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es[4*(6-c) +: 4], ea[8*(6-c) +: 8]);
      end
    end
    stop = 1'b0;
    checks++;
    if (writes != 2) begin
      errors++; $display("FAIL early_stop_writes got %0d exp 2", writes);
    end
  endtask

  task automatic test_ignored_start;
    logic [4*6-1:0] es;
    logic [8*6-1:0] ea;
    base_addr = 8'h77; burst_len = 8'd0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      checks++;
      if ({done, busy, Write, Read} !== CI || addr !== 8'h32) begin
        errors++; $display("FAIL zero_len cycle %0d got %h/%h exp %h/32", c, {done, busy, Write, Read}, addr, CI);
      end
    end
    // stop has priority over start in IDLE
    burst_len = 8'd2; stop = 1'b1;
    tick;
    stop = 1'b0; start = 1'b0;
    checks++;
    if ({done, busy, Write, Read} !== CI) begin
      errors++; $display("FAIL stop_over_start got %h exp %h", {done, busy, Write, Read}, CI);
    end
    es = {CR, CW, CR, CW, CK, CI};
    ea = {8'h50, 8'h50, 8'h51, 8'h51, 8'h52, 8'h52};
    base_addr = 8'h50; burst_len = 8'd2; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) begin
        base_addr = 8'h99; burst_len = 8'd7; delay_cycles = 8'd3;
      end
      if (c == 4) start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(6-c) +: 4] || addr !== ea[8*(6-c) +: 8]) begin
        errors++; $display("FAIL busy_start cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es[4*(6-c) +: 4], ea[8*(6-c) +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [4*3-1:0] es;
    logic [4*4-1:0] es2;
    logic [8*4-1:0] ea2;
    es = {CR, CW, CD};
    base_addr = 8'h60; burst_len = 8'd3; slowrun = 1'b1; delay_cycles = 8'd3; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es[4*(3-c) +: 4] || addr !== 8'h60) begin
        errors++; $display("FAIL rst_mid_pre cycle %0d got %h/%h exp %h/60", c, {done, busy, Write, Read}, addr, es[4*(3-c) +: 4]);
      end
    end
    rst = 1'b1;
    tick;
    rst = 1'b0; slowrun = 1'b0;
    checks++;
    if ({done, busy, Write, Read} !== CI || addr !== 8'h00) begin
      errors++; $display("FAIL rst_mid_idle got %h/%h exp %h/00", {done, busy, Write, Read}, addr, CI);
    end
    for (int c = 1; c <= 4; c++) begin
      tick;
      checks++;
      if ({done, busy, Write, Read} !== CI) begin
        errors++; $display("FAIL rst_mid_nodone cycle %0d got %h exp %h", c, {done, busy, Write, Read}, CI);
      end
    end
    es2 = {CR, CW, CK, CI};
    ea2 = {8'h70, 8'h70, 8'h71, 8'h71};
    base_addr = 8'h70; burst_len = 8'd1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, Write, Read} !== es2[4*(4-c) +: 4] || addr !== ea2[8*(4-c) +: 8]) begin
        errors++; $display("FAIL rst_mid_fresh cycle %0d got %h/%h exp %h/%h", c, {done, busy, Write, Read}, addr, es2[4*(4-c) +: 4], ea2[8*(4-c) +: 8]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slowrun;
    test_wrap;
    test_early_stop;
    test_ignored_start;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
